frame_streamer: RTL
===================

Name: frame_streamer

Overview:
- Parametrised successor to the per-render-clock frame dump.
- Snapshots the flattened renderer pixel bus on request and streams it row-major as LANES pixel codes per beat over a valid/ready interface.
- Sideband markers: start of frame, end of line, end of frame.
- Sits between renderer and any consumer (simulation dumper, UART/serial link, second display path). Tolerates consumer back-pressure and counts dropped frame requests.

Parameters:
- PX_WIDTH, 64, pixels per row; must be a multiple of LANES.
- PX_HEIGHT, 48, rows per frame.
- PX_BITS, 3, bits per pixel code.
- LANES, 1, pixels per output beat (1, 2, 4 or 8).
- CNT_W, 16, width of frame_count and drop_count.

Ports:
- clk  in  1  render clock; all logic on posedge.
- clr  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle capture request.
- pixel  in  PX_WIDTH*PX_HEIGHT*PX_BITS  flattened frame; pixel (x,y) at bits [(y*PX_WIDTH+x)*PX_BITS +: PX_BITS].
- busy  out  1  high from capture until the last beat is accepted.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_data  out  LANES*PX_BITS  lane k holds pixel x0+k in bits [k*PX_BITS +: PX_BITS].
- out_sof  out  1  first beat of frame.
- out_eol  out  1  last beat of a row.
- out_eof  out  1  last beat of frame.
- frame_count  out  CNT_W  completed frames; wraps.
- drop_count  out  CNT_W  rejected requests; saturates at all-ones.
- checksum  out  8  frame checksum (see Optional Feature).

Behaviour:
- Reset (clr=1 at posedge): state IDLE. busy, out_valid, out_sof, out_eol, out_eof = 0; out_data = 0; frame_count = 0; drop_count = 0; checksum = 0; x/y pointers = 0.
- States:
  - IDLE: frame_start=1 copies pixel into the internal snapshot register, clears pointers, goes to STREAM. busy=1 from the next cycle. First beat valid one cycle after the capture edge (latency 1).
  - STREAM: out_valid=1. Handshake completes on out_valid && out_ready at posedge.
    - On handshake: x += LANES. When x reaches PX_WIDTH: x=0, y+=1.
    - On the handshake of the eof beat: go to IDLE, frame_count += 1, busy and out_valid drop the next cycle.
- Markers:
  - out_sof = (x==0 && y==0).
  - out_eol = (x==PX_WIDTH-LANES).
  - out_eof = out_eol && (y==PX_HEIGHT-1).
- Back-pressure: while out_valid && !out_ready, out_data and all markers hold stable. Data is sourced only from the snapshot, so later changes on pixel have no effect mid-frame.
- Beats per frame = PX_WIDTH*PX_HEIGHT/LANES. No bubbles when out_ready is held high.
- frame_start while busy (including the cycle of the eof handshake): ignored; drop_count += 1 (saturating). Back-to-back frames therefore need at least one IDLE cycle.
- clr mid-frame: the stream aborts immediately. out_valid=0 next cycle, no partial eof, counters cleared.
- out_ready while out_valid=0: no effect.

Optional Feature:
- Macro: FRAME_STREAMER_CHECKSUM_EN.
- With the macro: an 8-bit accumulator sums, modulo 256, every pixel code of every accepted beat (all lanes, zero-extended). It clears at capture. On the eof handshake the final sum is registered to checksum and held until the next eof or clr.
- Without the macro: no accumulator logic; checksum is tied to 0.

Decomposition:
- Shared package/include: PX_WIDTH, PX_HEIGHT, PX_BITS defaults (same constants renderer uses), state encoding localparams (ST_IDLE, ST_STREAM), beat count function.
- One natural sub-module: fs_pixel_mux. It selects a LANES-wide slice from the snapshot given (x,y), purely combinational, kept separate for reuse by other readout paths.

Test Plan (PX_WIDTH=4, PX_HEIGHT=2, PX_BITS=3, LANES=2; pixel codes x+4y = 0..7):
- clr then frame_start, out_ready=1 -> 4 consecutive beats out_data = {1,0},{3,2},{5,4},{7,6}. sof on beat 1; eol on beats 2 and 4; eof on beat 4; frame_count=1; busy low after.
- Same frame with out_ready toggled 1,0,0,1,... -> data and markers stable during stalls; 4 accepted beats total; identical order.
- frame_start pulsed 3 times during streaming -> drop_count=3; frame_count=1; no extra beats.
- Change pixel input to all-7s after capture -> streamed data still 0..7.
- clr asserted after the 2nd accepted beat -> out_valid=0 next cycle; frame_count=0; next frame_start streams from sof.
- FRAME_STREAMER_CHECKSUM_EN defined -> checksum=28 after eof. Undefined -> checksum=0.

Source files
------------

// File: rtl/frame_streamer_pkg.sv
// Shared constants, state encoding and helpers for the frame streamer and
// other readout paths that walk the renderer pixel bus.
package frame_streamer_pkg;

    // Default geometry; these match the renderer's frame buffer.
    localparam int PX_WIDTH_DEF  = 64;
    localparam int PX_HEIGHT_DEF = 48;
    localparam int PX_BITS_DEF   = 3;
    localparam int LANES_DEF     = 1;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } fs_state_e;

    // Number of output beats needed to carry one complete frame.
    function automatic int beats_per_frame(input int width, input int height, input int lanes);
        return (width * height) / lanes;
    endfunction

endpackage

// File: rtl/fs_pixel_mux.sv
// Combinational lane selector: returns LANES consecutive pixel codes of row y
// starting at column x from a flattened frame snapshot.
module fs_pixel_mux
    import frame_streamer_pkg::*;
#(
    parameter int PX_WIDTH  = PX_WIDTH_DEF,
    parameter int PX_HEIGHT = PX_HEIGHT_DEF,
    parameter int PX_BITS   = PX_BITS_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int X_W       = $clog2(PX_WIDTH + 1),
    parameter int Y_W       = $clog2(PX_HEIGHT + 1)
) (
    input  logic [PX_WIDTH*PX_HEIGHT*PX_BITS-1:0] snap,
    input  logic [X_W-1:0]                        x,
    input  logic [Y_W-1:0]                        y,
    output logic [LANES*PX_BITS-1:0]              data
);

    localparam int FRAME_BITS = PX_WIDTH * PX_HEIGHT * PX_BITS;
    localparam int BEAT_BITS  = LANES * PX_BITS;
    localparam int IDX_W      = $clog2(FRAME_BITS);

    int               base;
    logic [IDX_W-1:0] idx;

    // Bit offset of pixel (x,y); lanes are adjacent so one slice covers them all.
    always_comb begin
        base = (int'(y) * PX_WIDTH + int'(x)) * PX_BITS;
        idx  = IDX_W'(base);
        data = snap[idx +: BEAT_BITS];
    end

endmodule

// File: rtl/frame_streamer.sv
// Frame streamer: snapshots the renderer pixel bus on frame_start and streams
// it row-major, LANES pixels per beat, over valid/ready with sof/eol/eof.
// Build option: FRAME_STREAMER_CHECKSUM_EN adds an 8-bit per-frame pixel sum.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no frame in flight; frame_start captures a snapshot
//   ST_STREAM | beats presented; advances on each valid/ready handshake
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int PX_WIDTH  = PX_WIDTH_DEF,
    parameter int PX_HEIGHT = PX_HEIGHT_DEF,
    parameter int PX_BITS   = PX_BITS_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                                  clk,
    input  logic                                  clr,
    input  logic                                  frame_start,
    input  logic [PX_WIDTH*PX_HEIGHT*PX_BITS-1:0] pixel,
    output logic                                  busy,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES*PX_BITS-1:0]              out_data,
    output logic                                  out_sof,
    output logic                                  out_eol,
    output logic                                  out_eof,
    output logic [CNT_W-1:0]                      frame_count,
    output logic [CNT_W-1:0]                      drop_count,
    output logic [7:0]                            checksum
);

    localparam int FRAME_BITS = PX_WIDTH * PX_HEIGHT * PX_BITS;
    localparam int BEAT_BITS  = LANES * PX_BITS;
    localparam int X_W        = $clog2(PX_WIDTH + 1);
    localparam int Y_W        = $clog2(PX_HEIGHT + 1);
    localparam logic [X_W-1:0] X_LAST = X_W'(PX_WIDTH - LANES);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(PX_HEIGHT - 1);

    fs_state_e              state_q, state_d;
    logic [FRAME_BITS-1:0]  snap_q, snap_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [Y_W-1:0]         y_q, y_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic [BEAT_BITS-1:0]   data_q, data_d;
    logic                   sof_q, sof_d;
    logic                   eol_q, eol_d;
    logic                   eof_q, eof_d;
    logic [CNT_W-1:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0]       dcnt_q, dcnt_d;
    logic [BEAT_BITS-1:0]   mux_data;
    logic                   hs;

    // The mux looks at the next pointers so beat data can be registered.
    fs_pixel_mux #(
        .PX_WIDTH  (PX_WIDTH),
        .PX_HEIGHT (PX_HEIGHT),
        .PX_BITS   (PX_BITS),
        .LANES     (LANES),
        .X_W       (X_W),
        .Y_W       (Y_W)
    ) u_mux (
        .snap (snap_d),
        .x    (x_d),
        .y    (y_d),
        .data (mux_data)
    );

    assign hs = valid_q && out_ready;

    // Next-state logic: capture, pointer walk, counters and beat outputs.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    snap_d  = pixel;
                    x_d     = '0;
                    y_d     = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (frame_start && (dcnt_q != '1)) begin
                    dcnt_d = dcnt_q + 1'b1;
                end
                if (hs) begin
                    if (eof_q) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                        x_d     = '0;
                        y_d     = '0;
                        fcnt_d  = fcnt_q + 1'b1;
                    end else if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + X_W'(LANES);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs only move on capture or handshake, so they hold during stalls.
        sof_d  = valid_d && (x_d == '0) && (y_d == '0);
        eol_d  = valid_d && (x_d == X_LAST);
        eof_d  = eol_d && (y_d == Y_LAST);
        data_d = valid_d ? mux_data : '0;
    end

`ifdef FRAME_STREAMER_CHECKSUM_EN
    logic [7:0] acc_q, acc_d;
    logic [7:0] csum_q, csum_d;
    logic [7:0] beat_sum;

    // Running modulo-256 sum of accepted pixel codes, published at eof.
    always_comb begin
        acc_d    = acc_q;
        csum_d   = csum_q;
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sum = beat_sum + 8'(data_q[k*PX_BITS +: PX_BITS]);
        end
        if (state_q == ST_IDLE) begin
            if (frame_start) begin
                acc_d = '0;
            end
        end else if (hs) begin
            acc_d = acc_q + beat_sum;
            if (eof_q) begin
                csum_d = acc_q + beat_sum;
            end
        end
    end

    // Checksum registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_q  <= '0;
            csum_q <= '0;
        end else begin
            acc_q  <= acc_d;
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    // State and output registers; clr aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            fcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            fcnt_q  <= fcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign busy        = busy_q;
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_sof     = sof_q;
    assign out_eol     = eol_q;
    assign out_eof     = eof_q;
    assign frame_count = fcnt_q;
    assign drop_count  = dcnt_q;

endmodule
